// File: rtl/io_output_reg_if.sv
// CPU-side IO bus for io_output_reg: address, store data, store strobe and
// combinational readback of the output port registers.
interface io_output_reg_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [31:0] io_rdata;

    // CPU side drives the store and reads back.
    modport master (
        output addr,
        output datain,
        output write_io_enable,
        input  io_rdata
    );

    // Peripheral side decodes the store and returns readback data.
    modport slave (
        input  addr,
        input  datain,
        input  write_io_enable,
        output io_rdata
    );
endinterface

// File: rtl/io_output_reg.sv
// Memory-mapped output port block: three 32-bit latched ports at 0xC0/0xC4/0xC8
// with a one-cycle update pulse per port, combinational readback, and an
// 8-digit multiplexed seven-segment scanner that shows out_port2 as hex.
module io_output_reg #(
    parameter int unsigned SCAN_DIV = 1000  // io_clk cycles per digit slot, 2..65535
) (
    input  logic                  io_clk,
    input  logic                  reset,
    io_output_reg_if.slave        bus,
    output logic [31:0]           out_port0,
    output logic [31:0]           out_port1,
    output logic [31:0]           out_port2,
    output logic [2:0]            out_valid,
    output logic [7:0]            seg_an,
    output logic [6:0]            seg_hex
);

    localparam logic [5:0]  ADDR_PORT0    = 6'b110000;  // 0xC0
    localparam logic [5:0]  ADDR_PORT1    = 6'b110001;  // 0xC4
    localparam logic [5:0]  ADDR_PORT2    = 6'b110010;  // 0xC8
    localparam logic [15:0] PRESCALE_LAST = 16'(SCAN_DIV - 1);

    // Hex digit to active-low segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [5:0]  word_addr;
    logic [2:0]  wr_sel;
    logic [31:0] rdata;
    logic [15:0] prescaler;
    logic        tick;
    logic [2:0]  digit_idx;
    logic [2:0]  next_digit;
    logic [3:0]  next_nibble;
    logic        unused_addr_bits;

    // Only the word address within the IO page takes part in decoding.
    assign word_addr        = bus.addr[7:2];
    assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};

    // One-hot select of the port written on this edge; none when the strobe is low.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wr_sel = 3'b000;
        if (bus.write_io_enable) begin
            case (word_addr)
                ADDR_PORT0: wr_sel = 3'b001;
                ADDR_PORT1: wr_sel = 3'b010;
                ADDR_PORT2: wr_sel = 3'b100;
                default:    wr_sel = 3'b000;
            endcase
        end
    end

    // Readback mux: matching port register, zero for every unmapped word.
    always_comb begin
        rdata = 32'h0;
        case (word_addr)
            ADDR_PORT0: rdata = out_port0;
            ADDR_PORT1: rdata = out_port1;
            ADDR_PORT2: rdata = out_port2;
            default:    rdata = 32'h0;
        endcase
    end

    assign bus.io_rdata = rdata;

    // Port registers and their update pulses; the pulse lines up with the new value.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            out_port0 <= 32'h0;
            out_port1 <= 32'h0;
            out_port2 <= 32'h0;
            out_valid <= 3'b000;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values; the scanner below relies on this to show the
            // old out_port2 nibble when a write and a tick share an edge.
            if (wr_sel[0]) out_port0 <= bus.datain;
            if (wr_sel[1]) out_port1 <= bus.datain;
            if (wr_sel[2]) out_port2 <= bus.datain;
            out_valid <= wr_sel;
        end
    end

    assign tick        = (prescaler == PRESCALE_LAST);
    assign next_digit  = digit_idx + 3'd1;
    assign next_nibble = out_port2[{next_digit, 2'b00} +: 4];

    // Digit-slot prescaler: counts 0..SCAN_DIV-1, the wrap edge is the tick.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            prescaler <= 16'h0;
        end else if (tick) begin
            prescaler <= 16'h0;
        end else begin
            prescaler <= prescaler + 16'h1;
        end
    end

    // Digit scanner: on each tick advance the index and register enable and segments.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            digit_idx <= 3'd0;
            seg_an    <= 8'hFE;
            seg_hex   <= 7'b1000000;
        end else if (tick) begin
            digit_idx <= next_digit;
            seg_an    <= ~(8'b0000_0001 << next_digit);
            seg_hex   <= hex_to_seg(next_nibble);
        end
    end

endmodule

// File: doc/io_output_reg.md
IO_OUTPUT_REG -- requirements
Module: io_output_reg

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: io_clk cycles per seven-segment digit slot, legal range 2..65535.
REQ-002 SHALL have port io_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port addr, input, 32 bits: CPU byte address; only addr[7:2] is decoded.
REQ-005 SHALL have port datain, input, 32 bits: CPU store data.
REQ-006 SHALL have port write_io_enable, input, 1 bit: CPU IO store strobe, sampled each edge.
REQ-007 SHALL have ports out_port0, out_port1 and out_port2, each an output of 32 bits: latched output port registers.
REQ-008 SHALL have port out_valid, output, 3 bits: one-cycle update pulse per port; bit n corresponds to port n.
REQ-009 SHALL have port io_rdata, output, 32 bits: readback of the output port registers.
REQ-010 SHALL have port seg_an, output, 8 bits: digit enables, active-low, one-hot-low.
REQ-011 SHALL have port seg_hex, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-012 SHALL decode writes as follows:
- write_io_enable=1 and addr[7:2]=6'b110000 (0xC0) -> out_port0 <= datain.
- 6'b110001 (0xC4) -> out_port1 <= datain.
- 6'b110010 (0xC8) -> out_port2 <= datain.
REQ-013 SHALL ignore writes to any other addr[7:2] value: no register change and no out_valid pulse.
REQ-014 SHALL make new port values visible on the output ports immediately after the write edge, i.e. one-edge write latency.
REQ-015 SHALL register out_valid[n] so that it is 1 for exactly the cycle following each accepted write to port n, coincident with the new value; back-to-back writes SHALL give back-to-back pulses.
REQ-016 SHALL make io_rdata combinational on addr[7:2]: 110000/110001/110010 select the matching port register; any other value gives 32'h0.
REQ-017 SHALL include a prescaler counting 0..SCAN_DIV-1 and wrapping to 0; the wrap edge is the "tick".
REQ-018 SHALL include a 3-bit digit index incremented on each tick, wrapping 7 -> 0.
REQ-019 SHALL, on each tick, register the displayed digit from the new index i:
- seg_an <= ~(8'b1 << i).
- seg_hex <= decode(out_port2[4i+3:4i]), using the out_port2 value held before that edge.
REQ-020 SHALL decode hex digits active-low over 0-F as follows:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000.
- 4=0011001, 5=0010010, 6=0000010, 7=1111000.
- 8=0000000, 9=0010000, A=0001000, b=0000011.
- C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 SHALL, when a write to port2 and a tick occur on the same edge, display the old nibble; the new nibble SHALL appear from the next tick that selects that digit.
REQ-022 SHALL hold seg_an and seg_hex stable between ticks and keep exactly one seg_an bit low at all times outside reset.

Reset
REQ-023 SHALL, while reset=1, immediately force the following regardless of io_clk:
- out_port0/1/2 = 0, out_valid = 0.
- prescaler = 0, digit index = 0.
- seg_an = 8'hFE, seg_hex = 7'b1000000.
REQ-024 SHALL discard any write presented on the edge at which reset deasserts or during reset; the first accepted write is at the first edge with reset=0.
REQ-025 SHALL, after reset release, produce the first tick SCAN_DIV edges later, showing digit 1.

Verification
REQ-026 SHALL be verified for reset then idle 3 cycles -> ports 0, out_valid 0, seg_an FE, seg_hex 1000000.
REQ-027 SHALL be verified for a write of 0x12345678 to 0xC0, then 0xDEADBEEF to 0xC4 on consecutive cycles -> ports update one edge later; out_valid = 001 then 010; io_rdata at 0xC4 = DEADBEEF.
REQ-028 SHALL be verified for a write to 0xCC, and for addr 0xC0 with write_io_enable=0 -> no port change; out_valid stays 0; io_rdata at 0xCC = 0.
REQ-029 SHALL be verified with SCAN_DIV=4 and out_port2=0x76543210 -> over 8 ticks seg_an walks FD,FB,...,7F,FE, with seg_hex showing 1,2,...,7,0 per REQ-020.
REQ-030 SHALL be verified with SCAN_DIV=4 for a write of 0xFFFFFFFF to 0xC8 on a tick edge -> that tick shows the old nibble; later ticks show F (0001110).
REQ-031 SHALL be verified for reset asserted mid-scan and mid-pulse, asynchronously between edges -> all outputs reach their reset values without a clock edge.
